// File: rtl/program_loader.sv
// Program loader: assembles little-endian bytes from a serial receiver into
// instruction words, writes them to instruction memory, then releases the core.
module program_loader #(
  parameter int                            INSTRUCTION_LENGTH = 32,
  parameter int                            PC_LENGTH          = 32,
  parameter int                            MAX_WORDS          = 64,
  parameter logic [INSTRUCTION_LENGTH-1:0] HALT_WORD          = 32'hFFFFFFFF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_start,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic                          wr_memory_instruction_enable,
  output logic [INSTRUCTION_LENGTH-1:0] instruction_to_write,
  output logic [PC_LENGTH-1:0]          address_to_write,
  output logic                          mips_enable,
  output logic                          loader_busy,
  output logic                          load_error
);

  // state | meaning: IDLE wait load_start | LOAD assemble/write | RUN core owns memory | ERROR overflow
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_ERROR} state_t;

  localparam int                   IDX_W     = $clog2(MAX_WORDS) + 1;
  localparam logic [PC_LENGTH-1:0] LAST_ADDR = PC_LENGTH'((MAX_WORDS - 1) * 4);

  state_t                          state, state_d;
  logic [1:0]                      byte_cnt, byte_cnt_d;
  logic [IDX_W-1:0]                word_idx, word_idx_d;
  logic [INSTRUCTION_LENGTH-1:0]   assembly_q, assembly_d;
  logic                            wr_d;
  logic [INSTRUCTION_LENGTH-1:0]   instr_d;
  logic [PC_LENGTH-1:0]            addr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                        <= S_IDLE;
      byte_cnt                     <= '0;
      word_idx                     <= '0;
      assembly_q                   <= '0;
      wr_memory_instruction_enable <= 1'b0;
      instruction_to_write         <= '0;
      address_to_write             <= '0;
      mips_enable                  <= 1'b0;
      loader_busy                  <= 1'b0;
      load_error                   <= 1'b0;
    end else begin
      state                        <= state_d;
      byte_cnt                     <= byte_cnt_d;
      word_idx                     <= word_idx_d;
      assembly_q                   <= assembly_d;
      wr_memory_instruction_enable <= wr_d;
      instruction_to_write         <= instr_d;
      address_to_write             <= addr_d;
      mips_enable                  <= (state_d == S_RUN);
      loader_busy                  <= (state_d == S_LOAD);
      load_error                   <= (state_d == S_ERROR);
    end
  end

  always_comb begin
    state_d    = state;
    byte_cnt_d = byte_cnt;
    word_idx_d = word_idx;
    assembly_d = assembly_q;
    wr_d       = 1'b0;
    instr_d    = instruction_to_write;
    addr_d     = address_to_write;

    case (state)
      S_IDLE, S_ERROR: begin
        if (load_start) begin
          state_d    = S_LOAD;
          byte_cnt_d = '0;
          word_idx_d = '0;
          assembly_d = '0;
        end
      end

      S_LOAD: begin
        if (rx_valid) begin
          assembly_d[{byte_cnt, 3'b000} +: 8] = rx_data;
          byte_cnt_d = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            wr_d       = 1'b1;
            instr_d    = assembly_d;
            addr_d     = PC_LENGTH'(word_idx) << 2;
            word_idx_d = word_idx + IDX_W'(1);
          end
        end
        // Leave LOAD only once the strobe for the deciding word has been seen.
        if (wr_memory_instruction_enable) begin
          if (instruction_to_write == HALT_WORD)
            state_d = S_RUN;
          else if (address_to_write == LAST_ADDR)
            state_d = S_ERROR;
        end
      end

      S_RUN: ;

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a byte-stream model predicts every memory
// write; a negedge monitor pops and compares whenever the strobe is seen.
module tb_program_loader;

  localparam int          MAXW = 4;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        wr_en;
  logic [31:0] instr;
  logic [31:0] addr;
  logic        mips;
  logic        busy;
  logic        err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] prog_bytes[$];

  bit         m_loading, m_halted, m_errored;
  logic [7:0] m_part[$];
  int         m_count;

  logic [31:0] hold_w, hold_a;

  always #5 clk = ~clk;

  program_loader #(
    .INSTRUCTION_LENGTH(32),
    .PC_LENGTH(32),
    .MAX_WORDS(MAXW),
    .HALT_WORD(HALT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_start(load_start),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .wr_memory_instruction_enable(wr_en),
    .instruction_to_write(instr),
    .address_to_write(addr),
    .mips_enable(mips),
    .loader_busy(busy),
    .load_error(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: the loader is a function of the accepted byte stream.
  task automatic m_reset();
    m_loading = 0; m_halted = 0; m_errored = 0; m_count = 0;
    m_part.delete();
  endtask

  task automatic m_start();
    if (!m_loading && !m_halted) begin
      m_loading = 1; m_errored = 0; m_count = 0;
      m_part.delete();
    end
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (!m_loading) return;
    m_part.push_back(b);
    if (m_part.size() == 4) begin
      wr_t w;
      w.word = {m_part[3], m_part[2], m_part[1], m_part[0]};
      w.addr = 32'(m_count * 4);
      exp_q.push_back(w);
      m_count++;
      m_part.delete();
      if (w.word == HALT) begin
        m_loading = 0; m_halted = 1;
      end else if (m_count == MAXW) begin
        m_loading = 0; m_errored = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      hold_w = '0;
      hold_a = '0;
    end else begin
      chk("wr_mips_exclusive", {31'b0, wr_en & mips}, 32'h0);
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe actual=%h@%h expected=none", instr, addr);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("strobe_word", instr, e.word);
          chk("strobe_addr", addr, e.addr);
          hold_w = e.word;
          hold_a = e.addr;
        end
      end else begin
        chk("hold_word", instr, hold_w);
        chk("hold_addr", addr, hold_a);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_start();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    m_byte(b);
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) prog_bytes.push_back(w[8*i +: 8]);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  task automatic send_prog(input int maxgap);
    while (prog_bytes.size() > 0) begin
      send_byte(prog_bytes.pop_front());
      if (maxgap > 0 && prog_bytes.size() > 0) idle($urandom_range(maxgap, 0));
    end
  endtask

  task automatic do_reset();
    rx_valid   = 1'b0;
    load_start = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_wr", {31'b0, wr_en}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_mips", {31'b0, mips}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    idle(2);
    reset = 1'b1;
    m_reset();
    tick();
  endtask

  task automatic end_check(input string tag);
    idle(2);
    chk({tag, "_mips"}, {31'b0, mips}, {31'b0, m_halted});
    chk({tag, "_err"}, {31'b0, err}, {31'b0, m_errored});
    chk({tag, "_busy"}, {31'b0, busy}, {31'b0, m_loading});
  endtask

  initial begin
    m_reset();
    idle(2);
    do_reset();
    idle(3);
    chk("no_autoload_busy", {31'b0, busy}, 32'h0);

    // Known first word, then two more and a HALT at the last slot.
    pulse_start();
    push_word(32'h20080013);
    send_prog(2);
    chk("first_strobe", {31'b0, wr_en}, 32'h1);
    chk("first_strobe_mips", {31'b0, mips}, 32'h0);
    push_word(rand_word());
    push_word(rand_word());
    push_word(HALT);
    send_prog(2);
    tick();
    chk("halt_mips_next_cycle", {31'b0, mips}, 32'h1);
    chk("halt_busy", {31'b0, busy}, 32'h0);

    // RUN ignores receiver and load_start.
    for (int i = 0; i < 12; i++) begin
      load_start = 1'($urandom);
      rx_valid   = 1'($urandom);
      rx_data    = 8'($urandom);
      tick();
      chk("run_mips_held", {31'b0, mips}, 32'h1);
    end
    load_start = 1'b0;
    rx_valid   = 1'b0;

    // Back-to-back bytes.
    do_reset();
    pulse_start();
    push_word(rand_word());
    push_word(rand_word());
    push_word(HALT);
    send_prog(0);
    end_check("b2b");

    // Overflow into ERROR, ignored bytes, then reload.
    do_reset();
    pulse_start();
    for (int i = 0; i < MAXW; i++) push_word(rand_word());
    send_prog(1);
    end_check("overflow");
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    chk("error_held", {31'b0, err}, 32'h1);
    pulse_start();
    push_word(rand_word());
    push_word(HALT);
    send_prog(1);
    end_check("reload");

    // Reset with a partial word in flight.
    do_reset();
    pulse_start();
    send_byte(8'hAA);
    send_byte(8'hBB);
    do_reset();
    pulse_start();
    push_word(rand_word());
    push_word(HALT);
    send_prog(1);
    end_check("after_midreset");

    // load_start inside LOAD keeps the partial word.
    do_reset();
    pulse_start();
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_start();
    send_byte(8'h33);
    send_byte(8'h44);
    push_word(HALT);
    send_prog(0);
    end_check("start_in_load");

    for (int it = 0; it < 8; it++) begin
      int kind;
      int n;
      do_reset();
      pulse_start();
      kind = $urandom_range(2, 0);
      if (kind == 0) begin
        n = $urandom_range(MAXW - 1, 0);
        for (int i = 0; i < n; i++) push_word(rand_word());
        push_word(HALT);
      end else if (kind == 1) begin
        for (int i = 0; i < MAXW; i++) push_word(rand_word());
      end else begin
        n = $urandom_range(MAXW - 1, 0);
        for (int i = 0; i < n; i++) push_word(rand_word());
        n = $urandom_range(3, 0);
        for (int i = 0; i < n; i++) prog_bytes.push_back(8'($urandom));
      end
      send_prog(2);
      end_check("random");
    end

    idle(3);
    chk("all_strobes_seen", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter INSTRUCTION_LENGTH, default 32, instruction word width.
REQ-002 Parameter PC_LENGTH, default 32, byte-address width.
REQ-003 Parameter MAX_WORDS, default 64, instruction memory depth in words.
REQ-004 Parameter HALT_WORD, default 32'hFFFFFFFF, end-of-program marker.
REQ-005 clk  input  1  single system clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-007 load_start  input  1  single-cycle request to begin a program load.
REQ-008 rx_valid  input  1  one-cycle strobe; rx_data holds a valid byte.
REQ-009 rx_data  input  8  program byte from the serial receiver.
REQ-010 wr_memory_instruction_enable  output  1  one-cycle instruction memory write strobe.
REQ-011 instruction_to_write  output  INSTRUCTION_LENGTH  word to write.
REQ-012 address_to_write  output  PC_LENGTH  byte address of the word, multiple of 4.
REQ-013 mips_enable  output  1  level; processor may run, instruction memory write port locked.
REQ-014 loader_busy  output  1  high while in LOAD.
REQ-015 load_error  output  1  high while in ERROR.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, RUN, ERROR; all outputs registered.
REQ-017 IDLE: load_start=1 -> LOAD; byte count, word index, assembly register cleared on the transition.
REQ-018 LOAD: each rx_valid cycle accepts one byte; byte k (k=0..3) SHALL go to assembly bits [8k+7:8k] (little-endian).
REQ-019 Accepting byte 3 SHALL, next cycle, drive wr_memory_instruction_enable=1 for exactly one cycle, instruction_to_write=assembled word, address_to_write=word_index*4.
REQ-020 word_index SHALL increment by 1 after each write; byte count wraps 3->0.
REQ-021 rx_valid during the write-strobe cycle SHALL be accepted as byte 0 of the next word without corrupting the outputs of the current write.
REQ-022 Written word equal to HALT_WORD SHALL still be written; the cycle after that strobe FSM -> RUN and mips_enable=1.
REQ-023 Write of word index MAX_WORDS-1 that is not HALT_WORD SHALL be followed by ERROR; no further writes.
REQ-024 RUN: mips_enable held 1, wr_memory_instruction_enable held 0, rx_valid and load_start ignored; exit only by reset.
REQ-025 ERROR: load_error=1, mips_enable=0, rx_valid ignored; load_start=1 -> LOAD with counters cleared.
REQ-026 load_start while in LOAD SHALL be ignored; partial word is kept.
REQ-027 wr_memory_instruction_enable and mips_enable SHALL never be 1 in the same cycle.
REQ-028 instruction_to_write and address_to_write SHALL hold their last written values outside strobe cycles.
REQ-029 Outside LOAD, rx_valid SHALL not change byte count or assembly register.

Reset
REQ-030 reset=0 SHALL immediately, independent of clk, force IDLE and all outputs to 0, byte count 0, word index 0.
REQ-031 Reset mid-LOAD SHALL discard any partial word; no write strobe SHALL occur during or on release of reset.
REQ-032 First transition after reset release SHALL require load_start; no automatic load.

Verification
REQ-033 Reset, load_start, bytes 13 00 08 20 -> one strobe, instruction_to_write=32'h20080013, address_to_write=0, mips_enable=0.
REQ-034 Three words then FF FF FF FF -> strobes at addresses 0,4,8,12, last word 32'hFFFFFFFF, mips_enable=1 the cycle after the last strobe, loader_busy=0.
REQ-035 Back-to-back rx_valid every cycle for 8 bytes -> two strobes, correct words at addresses 0 and 4, no lost byte.
REQ-036 MAX_WORDS=4, four non-HALT words -> four strobes, then load_error=1; load_start -> LOAD, next word written at address 0.
REQ-037 reset=0 asserted after 2 bytes of a word -> outputs 0 asynchronously; after release, load_start plus 4 bytes -> word built only from new bytes at address 0.
REQ-038 In RUN, rx_valid and load_start pulses -> no strobe, mips_enable stays 1.
